keypad_scanner: RTL

//  Parametrised ROWS x COLS matrix-keypad scanner; successor to the fixed 4x4 keypad path.

---
 rtl/keypad_scanner.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   ROWS x COLS matrix-keypad scanner with an integrated scan divider,
//   debounce, single-key/ghost rejection and a first-word-fall-through
//   key-code FIFO read over a valid/ready handshake.
//
// Ports
//   clk, rst    system clock, asynchronous active-high reset
//   row         row sense, active-low, asynchronous to clk
//   col         column drive, active-low one-hot
//   key_code    FIFO head, code = col_idx*ROWS + row_idx
//   key_valid   FIFO non-empty
//   key_ready   consumer takes the head when key_valid && key_ready
//   fifo_count  number of entries held
//   overflow    sticky, a code was dropped on a full FIFO
//
// Build option
//   KEYPAD_REPEAT_EN: auto-repeat of a held key after REPEAT_DELAY ticks,
//   then every REPEAT_RATE ticks. Without it REPEAT_* are ignored.
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE     = 4,
    parameter int FIFO_DEPTH   = 8,
    parameter int REPEAT_DELAY = 250,
    parameter int REPEAT_RATE  = 50,
    localparam int CODE_W      = $clog2(ROWS * COLS),
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ROWS-1:0]   row_s1_q, row_s2_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [COL_W-1:0]  col_idx_q, col_idx_d, col_nxt;
    logic [CODE_W-1:0] code_q, code_d, code_now, push_code;
    logic [ROWS-1:0]   pat_q, pat_d;
    logic [DB_W-1:0]   cnt_q, cnt_d, rel_q, rel_d;
    logic [ROWS-1:0]   rows_low;
    logic [ROW_W-1:0]  row_idx;
    logic              tick, one_low, all_high;
    logic              fsm_push, rep_push, push_req;

    logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CODE_W-1:0] last_q, last_d;
    logic              ovf_q, ovf_d;
    logic              full, pop, push_ok;

    // Row decode on the synchronised sample: exactly one row low is a key,
    // anything with two or more rows low in one column is treated as ghosting.
    always_comb begin
        rows_low = ~row_s2_q;
        one_low  = (rows_low != '0) && ((rows_low & (rows_low - ROWS'(1))) == '0);
        all_high = (row_s2_q == '1);
        row_idx  = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (rows_low[i]) row_idx = ROW_W'(i);
        end
        code_now = CODE_W'(col_idx_q) * CODE_W'(ROWS) + CODE_W'(row_idx);
        col_nxt  = (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + COL_W'(1);
        tick     = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        for (int c = 0; c < COLS; c++) begin
            col[c] = (col_idx_q != COL_W'(c));
        end
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        code_d    = code_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        rel_d     = rel_q;
        fsm_push  = 1'b0;
        push_code = code_q;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (one_low) begin
                        code_d    = code_now;
                        pat_d     = row_s2_q;
                        cnt_d     = DB_W'(1);
                        rel_d     = '0;
                        push_code = code_now;
                        if (DEBOUNCE == 1) begin
                            fsm_push = 1'b1;
                            state_d  = ST_HELD;
                        end else begin
                            state_d  = ST_DEBOUNCE;
                        end
                    end else begin
                        col_idx_d = col_nxt;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_s2_q == pat_q) begin
                        cnt_d = cnt_q + DB_W'(1);
                        if (cnt_q + DB_W'(1) == DB_W'(DEBOUNCE)) begin
                            fsm_push = 1'b1;
                            rel_d    = '0;
                            state_d  = ST_HELD;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_nxt;
                    end
                end
                ST_HELD: begin
                    if (all_high) begin
                        rel_d = rel_q + DB_W'(1);
                        if (rel_q + DB_W'(1) == DB_W'(DEBOUNCE)) begin
                            rel_d     = '0;
                            state_d   = ST_SCAN;
                            col_idx_d = col_nxt;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_target;
    logic             rep_arm_q, rep_arm_d;

    // rep_arm_q marks that the first (long) repeat delay has elapsed.
    always_comb begin
        rep_cnt_d  = rep_cnt_q;
        rep_arm_d  = rep_arm_q;
        rep_push   = 1'b0;
        rep_target = rep_arm_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY);
        if (state_q != ST_HELD) begin
            rep_cnt_d = '0;
            rep_arm_d = 1'b0;
        end else if (tick) begin
            if (row_s2_q == pat_q) begin
                if (rep_cnt_q + REP_W'(1) == rep_target) begin
                    rep_push  = 1'b1;
                    rep_cnt_d = '0;
                    rep_arm_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end else begin
                rep_cnt_d = '0;
                rep_arm_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q <= '0;
            rep_arm_q <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_arm_q <= rep_arm_d;
        end
    end
`else
    logic unused_repeat_params;
    assign unused_repeat_params = ((REPEAT_DELAY + REPEAT_RATE) != 0);
    assign rep_push = 1'b0;
`endif

    // FIFO: a push into a full FIFO only lands if the head leaves the same cycle.
    always_comb begin
        push_req  = fsm_push | rep_push;
        key_valid = (count_q != '0);
        pop       = key_valid & key_ready;
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        push_ok   = push_req & (~full | pop);
        ovf_d     = ovf_q | (push_req & full & ~pop);
        wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        last_d    = pop ? mem_q[rd_ptr_q] : last_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        key_code   = key_valid ? mem_q[rd_ptr_q] : last_q;
        fifo_count = count_q;
        overflow   = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q  <= '1;
            row_s2_q  <= '1;
            state_q   <= ST_SCAN;
            div_q     <= '0;
            col_idx_q <= '0;
            code_q    <= '0;
            pat_q     <= '1;
            cnt_q     <= '0;
            rel_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            last_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            row_s1_q  <= row;
            row_s2_q  <= row_s1_q;
            state_q   <= state_d;
            div_q     <= div_d;
            col_idx_q <= col_idx_d;
            code_q    <= code_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            rel_q     <= rel_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule
